pulse_sync_stretch: RTL and testbench

Multi-channel pulse synchroniser and stretcher. Each channel samples an asynchronous input (a level or a sufficiently long pulse from a foreign domain) into CLK, detects rising edges, emits a single-cycle pulse and a programmable-length stretched pulse, and counts edges dropped in non-retrigger mode. The block sits at the boundary between trigger/readout logic and the bus-clocked control domain; the counters and strobes it produces are consumed there.

---
 rtl/pulse_sync_stretch.sv | 87 ++++++++
 tb/tb_pulse_sync_stretch.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_sync_stretch.sv
// Multi-channel pulse synchroniser with rising-edge detect, single-cycle pulse,
// programmable stretch window and saturating per-channel missed-edge counters.
module pulse_sync_stretch #(
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 3,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [CHANNELS-1:0]           PULSE_IN,
  input  logic [CNT_WIDTH-1:0]          STRETCH_LEN,
  input  logic                          RETRIGGER,
  input  logic                          CLR_MISSED,
  output logic [CHANNELS-1:0]           PULSE_OUT,
  output logic [CHANNELS-1:0]           STRETCH_OUT,
  output logic [CHANNELS*CNT_WIDTH-1:0] MISSED
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0] sync_q   [CHANNELS];
  logic [CHANNELS-1:0]    dly_q;
  logic [CHANNELS-1:0]    pulse_q;
  logic [CNT_WIDTH-1:0]   cnt_q    [CHANNELS];
  logic [CNT_WIDTH-1:0]   cnt_d    [CHANNELS];
  logic [CNT_WIDTH-1:0]   missed_q [CHANNELS];
  logic [CNT_WIDTH-1:0]   missed_d [CHANNELS];
  logic [CHANNELS-1:0]    rise_d;
  logic [CHANNELS-1:0]    miss_d;

  // An edge seen while the window is still open (including its last cycle) is
  // either a reload or a miss; the window itself keeps counting down on a miss.
  always_comb begin
    rise_d = '0;
    miss_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_d[i]    = cnt_q[i];
      missed_d[i] = missed_q[i];
      rise_d[i]   = sync_q[i][SYNC_STAGES-1] & ~dly_q[i];
      if (cnt_q[i] != '0) begin
        cnt_d[i] = cnt_q[i] - CNT_ONE;
      end
      if (rise_d[i]) begin
        if ((cnt_q[i] == '0) || RETRIGGER) begin
          cnt_d[i] = STRETCH_LEN;
        end else begin
          miss_d[i] = 1'b1;
        end
      end
      if (CLR_MISSED) begin
        missed_d[i] = '0;
      end else if (miss_d[i] && (missed_q[i] != CNT_MAX)) begin
        missed_d[i] = missed_q[i] + CNT_ONE;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      dly_q   <= '0;
      pulse_q <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        sync_q[i]   <= '0;
        cnt_q[i]    <= '0;
        missed_q[i] <= '0;
      end
    end else begin
      pulse_q <= rise_d;
      for (int i = 0; i < CHANNELS; i++) begin
        sync_q[i]   <= {sync_q[i][SYNC_STAGES-2:0], PULSE_IN[i]};
        dly_q[i]    <= sync_q[i][SYNC_STAGES-1];
        cnt_q[i]    <= cnt_d[i];
        missed_q[i] <= missed_d[i];
      end
    end
  end

  always_comb begin
    PULSE_OUT = pulse_q;
    for (int i = 0; i < CHANNELS; i++) begin
      STRETCH_OUT[i]                   = (cnt_q[i] != '0);
      MISSED[i*CNT_WIDTH +: CNT_WIDTH] = missed_q[i];
    end
  end

endmodule

// File: tb/tb_pulse_sync_stretch.sv
// Bench for pulse_sync_stretch: directed scenarios plus randomized traffic,
// every cycle checked against a history/window-end reference model.
module tb_pulse_sync_stretch;

  localparam int CH = 4;
  localparam int S  = 3;
  localparam int CW = 8;
  localparam int MW = CH * CW;
  localparam int EW = 2 * CH + MW;

  // clock / reset
  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic [CH-1:0] PULSE_IN = '0;
  logic [CW-1:0] STRETCH_LEN = '0;
  logic          RETRIGGER = 1'b0;
  logic          CLR_MISSED = 1'b0;
  logic [CH-1:0] PULSE_OUT;
  logic [CH-1:0] STRETCH_OUT;
  logic [MW-1:0] MISSED;

  always #5 CLK = ~CLK;

  pulse_sync_stretch #(.CHANNELS(CH), .SYNC_STAGES(S), .CNT_WIDTH(CW)) dut (
    .CLK(CLK), .RST(RST), .PULSE_IN(PULSE_IN), .STRETCH_LEN(STRETCH_LEN),
    .RETRIGGER(RETRIGGER), .CLR_MISSED(CLR_MISSED), .PULSE_OUT(PULSE_OUT),
    .STRETCH_OUT(STRETCH_OUT), .MISSED(MISSED)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // reference model: input history, absolute window end per channel, counters
  logic [CH-1:0] hq[$];
  int            end_c[CH];
  logic [MW-1:0] missed_m;
  logic [EW-1:0] exp_q[$];

  // observations accumulated per scenario
  int            obs_p[CH];
  int            obs_s[CH];
  int            obs_r[CH];
  int            first_p[CH];
  int            n_all;
  logic [CH-1:0] prev_s;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    hq.delete();
    repeat (S + 2) hq.push_back('0);
    for (int i = 0; i < CH; i++) end_c[i] = 0;
    missed_m = '0;
  endtask

  task automatic clear_obs();
    for (int i = 0; i < CH; i++) begin
      obs_p[i] = 0; obs_s[i] = 0; obs_r[i] = 0; first_p[i] = -1;
    end
    n_all  = 0;
    prev_s = STRETCH_OUT;
  endtask

  // rising edges that the next clock edge will turn into pulses
  function automatic logic [CH-1:0] peek_rise();
    return hq[S-1] & ~hq[S];
  endfunction

  function automatic logic [CH-1:0] window_open();
    logic [CH-1:0] a;
    for (int i = 0; i < CH; i++) a[i] = (cyc < end_c[i]);
    return a;
  endfunction

  function automatic logic [CW-1:0] miss_of(input int ch);
    return MISSED[ch*CW +: CW];
  endfunction

  // predict the coming edge, advance one clock, compare
  task automatic tick();
    logic [CH-1:0] e, st, miss;
    logic [EW-1:0] ex;
    cyc++;
    e = '0; st = '0; miss = '0;
    if (RST) begin
      model_reset();
    end else begin
      hq.push_front(PULSE_IN);
      void'(hq.pop_back());
      e = hq[S] & ~hq[S+1];
      for (int i = 0; i < CH; i++) begin
        if (e[i]) begin
          if ((cyc - 1 >= end_c[i]) || RETRIGGER) end_c[i] = cyc + int'(STRETCH_LEN);
          else miss[i] = 1'b1;
        end
        st[i] = (cyc < end_c[i]);
        if (CLR_MISSED) missed_m[i*CW +: CW] = '0;
        else if (miss[i] && (missed_m[i*CW +: CW] != '1))
          missed_m[i*CW +: CW] = missed_m[i*CW +: CW] + CW'(1);
      end
    end
    exp_q.push_back({e, st, missed_m});
    @(posedge CLK);
    #1;
    ex = exp_q.pop_front();
    check("pulse_out",   64'(PULSE_OUT),   64'(ex[EW-1 -: CH]));
    check("stretch_out", 64'(STRETCH_OUT), 64'(ex[MW+CH-1 -: CH]));
    check("missed",      64'(MISSED),      64'(ex[MW-1:0]));
    for (int i = 0; i < CH; i++) begin
      if (PULSE_OUT[i]) begin
        obs_p[i]++;
        if (first_p[i] < 0) first_p[i] = cyc;
      end
      if (STRETCH_OUT[i]) obs_s[i]++;
      if (STRETCH_OUT[i] && !prev_s[i]) obs_r[i]++;
    end
    if (PULSE_OUT == '1) n_all++;
    prev_s = STRETCH_OUT;
  endtask

  task automatic drive_pulse(input int ch, input int hi, input int lo);
    PULSE_IN[ch] = 1'b1;
    repeat (hi) tick();
    PULSE_IN[ch] = 1'b0;
    repeat (lo) tick();
  endtask

  initial begin
    int            rise;
    int            rel;
    int            hold[CH];
    logic          done;
    logic [CH-1:0] pk, op;

    model_reset();
    clear_obs();
    RST = 1'b1;
    repeat (3) tick();
    check("rst_missed", 64'(MISSED), 64'(0));
    check("rst_stretch", 64'(STRETCH_OUT), 64'(0));
    RST = 1'b0;

    // single pulse on ch0
    STRETCH_LEN = 8'd5; RETRIGGER = 1'b1;
    clear_obs();
    rise = cyc + 1;
    drive_pulse(0, 3, 12);
    check("t1_latency", 64'(first_p[0] - rise), 64'(S));
    check("t1_pulse_n", 64'(obs_p[0]), 64'(1));
    check("t1_stretch_n", 64'(obs_s[0]), 64'(5));
    check("t1_others", 64'(obs_p[1] + obs_p[2] + obs_p[3] + obs_s[1] + obs_s[2] + obs_s[3]), 64'(0));

    // retrigger extends the window
    STRETCH_LEN = 8'd10; RETRIGGER = 1'b1;
    clear_obs();
    drive_pulse(1, 3, 3);
    drive_pulse(1, 3, 12);
    check("t2_pulse_n", 64'(obs_p[1]), 64'(2));
    check("t2_stretch_n", 64'(obs_s[1]), 64'(16));
    check("t2_one_window", 64'(obs_r[1]), 64'(1));
    check("t2_missed", 64'(miss_of(1)), 64'(0));

    // non-retrigger drops and counts the second edge
    RETRIGGER = 1'b0;
    clear_obs();
    drive_pulse(1, 3, 3);
    drive_pulse(1, 3, 12);
    check("t3_pulse_n", 64'(obs_p[1]), 64'(2));
    check("t3_stretch_n", 64'(obs_s[1]), 64'(10));
    check("t3_missed", 64'(miss_of(1)), 64'(1));

    repeat (299) begin
      drive_pulse(1, 3, 3);
      drive_pulse(1, 3, 12);
    end
    check("t3_saturate", 64'(miss_of(1)), 64'(255));

    // plain clear, then one counted miss, then a miss coinciding with clear
    CLR_MISSED = 1'b1; tick(); CLR_MISSED = 1'b0;
    check("clr_plain", 64'(MISSED), 64'(0));
    drive_pulse(1, 3, 3);
    drive_pulse(1, 3, 12);
    check("clr_then_miss", 64'(miss_of(1)), 64'(1));
    clear_obs();
    PULSE_IN[1] = 1'b1; repeat (3) tick();
    PULSE_IN[1] = 1'b0; repeat (3) tick();
    PULSE_IN[1] = 1'b1;
    done = 1'b0;
    for (int n = 0; n < 10 && !done; n++) begin
      pk = peek_rise();
      op = window_open();
      if (pk[1] && op[1]) begin
        CLR_MISSED = 1'b1; tick(); CLR_MISSED = 1'b0;
        done = 1'b1;
      end else begin
        tick();
      end
    end
    PULSE_IN[1] = 1'b0;
    repeat (12) tick();
    check("clrwin_found", 64'(done), 64'(1));
    check("clrwin_edges", 64'(obs_p[1]), 64'(2));
    check("clrwin_missed", 64'(MISSED), 64'(0));

    // zero length, all channels together
    STRETCH_LEN = 8'd0; RETRIGGER = 1'b1;
    clear_obs();
    PULSE_IN = '1; repeat (3) tick();
    PULSE_IN = '0; repeat (6) tick();
    check("len0_together", 64'(n_all), 64'(1));
    check("len0_pulses", 64'(obs_p[0] + obs_p[1] + obs_p[2] + obs_p[3]), 64'(4));
    check("len0_stretch", 64'(obs_s[0] + obs_s[1] + obs_s[2] + obs_s[3]), 64'(0));
    check("len0_missed", 64'(MISSED), 64'(0));

    // reset mid-stretch with input held high
    STRETCH_LEN = 8'd7;
    PULSE_IN[2] = 1'b1;
    for (int n = 0; n < 20 && !STRETCH_OUT[2]; n++) tick();
    repeat (2) tick();
    check("rst_pre_stretch", 64'(STRETCH_OUT[2]), 64'(1));
    RST = 1'b1;
    #1;
    check("rst_async_pulse", 64'(PULSE_OUT), 64'(0));
    check("rst_async_stretch", 64'(STRETCH_OUT), 64'(0));
    check("rst_async_missed", 64'(MISSED), 64'(0));
    repeat (2) tick();
    STRETCH_LEN = 8'd9;
    clear_obs();
    RST = 1'b0;
    rel = cyc;
    repeat (12) tick();
    PULSE_IN[2] = 1'b0;
    repeat (4) tick();
    check("rel_latency", 64'(first_p[2] - rel), 64'(S + 1));
    check("rel_pulse_n", 64'(obs_p[2]), 64'(1));
    check("rel_stretch_n", 64'(obs_s[2]), 64'(9));

    // randomized traffic
    for (int i = 0; i < CH; i++) hold[i] = 1;
    repeat (2000) begin
      for (int i = 0; i < CH; i++) begin
        hold[i]--;
        if (hold[i] == 0) begin
          PULSE_IN[i] = ~PULSE_IN[i];
          hold[i] = $urandom_range(1, 6);
        end
      end
      if ($urandom_range(0, 7) == 0) STRETCH_LEN = CW'($urandom_range(1, 12));
      RETRIGGER  = 1'($urandom_range(0, 1));
      CLR_MISSED = ($urandom_range(0, 31) == 0);
      tick();
    end
    CLR_MISSED = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
